// File: rtl/regbank_pkg.sv
// Shared types and constants for the parametrised register bank.
package regbank_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   localparam logic [63:0] REGBANK_PROT_DEFAULT = 64'hE000;
   localparam int unsigned REGBANK_MAX_DEPTH    = 64;

endpackage

// File: rtl/regbank_rdport.sv
// Registered read port: address decode, optional write-through forwarding
// (enabled by REGBANK_BYPASS_EN), and rd_data/rd_valid flops.
module regbank_rdport
   import regbank_pkg::*;
#(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [WIDTH-1:0]  regs [DEPTH],
   input  logic              wr_fwd,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   output logic [WIDTH-1:0]  rd_data,
   output logic              rd_valid
);

   logic             in_range_c;
   logic [WIDTH-1:0] rd_word_c;

   assign in_range_c = (32'(rd_addr) < DEPTH);

`ifdef REGBANK_BYPASS_EN
   // wr_fwd is only raised for legal writes, so forwarded data is always in range
   always_comb begin
      rd_word_c = '0;
      if (wr_fwd && (wr_addr == rd_addr)) begin
         rd_word_c = wr_data;
      end else if (in_range_c) begin
         rd_word_c = regs[rd_addr];
      end
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{wr_fwd, wr_addr, wr_data};

   always_comb begin
      rd_word_c = '0;
      if (in_range_c) begin
         rd_word_c = regs[rd_addr];
      end
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_data <= rd_word_c;
         end
      end
   end

endmodule

// File: rtl/regbank_param.sv
// Parametrised register bank: one protected write port, two registered read
// ports and a soft-clear sweep. Optional forwarding via REGBANK_BYPASS_EN.
module regbank_param
   import regbank_pkg::*;
#(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned ADDR_W    = $clog2(DEPTH),
   parameter logic [63:0] PROT_MASK = REGBANK_PROT_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en_a,
   input  logic [ADDR_W-1:0] rd_addr_a,
   output logic [WIDTH-1:0]  rd_data_a,
   output logic              rd_valid_a,
   input  logic              rd_en_b,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [WIDTH-1:0]  rd_data_b,
   output logic              rd_valid_b,
   input  logic              clr_req,
   output logic              busy,
   output logic              wr_err,
   input  logic              err_clr
);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] ptr, ptr_nxt;
   logic [WIDTH-1:0]  regs [DEPTH];

   logic clr_start_c, wr_ok_c, wr_legal_c, wr_illegal_c;
   logic rd_en_a_c, rd_en_b_c;

   // busy comes straight from the state flop
   assign busy = (state == CLEAR);

   // A write in the same cycle a sweep starts is dropped, not flagged
   assign clr_start_c  = (state == IDLE) && clr_req;
   assign wr_ok_c      = wr_en && !busy && !clr_start_c;
   assign wr_legal_c   = wr_ok_c && (32'(wr_addr) < DEPTH) && !PROT_MASK[wr_addr];
   assign wr_illegal_c = wr_ok_c && !wr_legal_c;

   assign rd_en_a_c = rd_en_a && !busy;
   assign rd_en_b_c = rd_en_b && !busy;

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      unique case (state)
         IDLE: begin
            if (clr_req) begin
               state_nxt = CLEAR;
               ptr_nxt   = '0;
            end
         end
         CLEAR: begin
            ptr_nxt = ptr + ADDR_W'(1);
            if (32'(ptr) == DEPTH - 1) begin
               state_nxt = IDLE;
               ptr_nxt   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         ptr    <= '0;
         wr_err <= 1'b0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         if (wr_illegal_c) begin
            wr_err <= 1'b1;
         end else if (err_clr) begin
            wr_err <= 1'b0;
         end
      end
   end

   // Storage: the sweep overrides the write port, including protected entries
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (busy) begin
         regs[ptr] <= '0;
      end else if (wr_legal_c) begin
         regs[wr_addr] <= wr_data;
      end
   end

   regbank_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd_a (
      .clk      (clk),
      .reset    (reset),
      .rd_en    (rd_en_a_c),
      .rd_addr  (rd_addr_a),
      .regs     (regs),
      .wr_fwd   (wr_legal_c),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_data  (rd_data_a),
      .rd_valid (rd_valid_a)
   );

   regbank_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd_b (
      .clk      (clk),
      .reset    (reset),
      .rd_en    (rd_en_b_c),
      .rd_addr  (rd_addr_b),
      .regs     (regs),
      .wr_fwd   (wr_legal_c),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_data  (rd_data_b),
      .rd_valid (rd_valid_b)
   );

endmodule
